// File: rtl/spi_tx.sv
// SPI mode-3 master: one byte out on MOSI (MSB first) while one byte is sampled from MISO.
// Consecutive bytes are chained while chip select stays low.
module spi_tx #(
  parameter int CLOCK_DIVIDER = 8
) (
  input  logic       clock,
  input  logic       reset,
  output logic       SPI_clock,
  output logic       SPI_out,
  input  logic       SPI_in,
  output logic       SPI_not_chip_select,
  input  logic       in_data_valid,
  input  logic [7:0] in_data,
  output logic       in_data_ready,
  output logic       out_data_valid,
  output logic [7:0] out_data,
  output logic       active
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLOCK_DIVIDER - 1);

  state_t     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] out_q, out_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;
  logic       cs_n_q, cs_n_d;
  logic       odv_q, odv_d;
  logic       taken_q, taken_d;
  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       period_end;
  logic       accept;

  assign in_data_ready = (state_q == IDLE) || ((state_q == HOLD) && !taken_q);
  assign accept        = in_data_valid && in_data_ready;
  assign period_end    = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    out_d   = out_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    odv_d   = 1'b0;
    taken_d = taken_q;
    sync1_d = SPI_in;
    sync2_d = sync1_q;

    unique case (state_q)
      IDLE: begin
        sclk_d  = 1'b1;
        mosi_d  = 1'b1;
        cs_n_d  = 1'b1;
        div_d   = '0;
        bit_d   = '0;
        taken_d = 1'b0;
        if (accept) begin
          tx_d    = in_data;
          cs_n_d  = 1'b0;
          state_d = SETUP;
        end
      end

      SETUP: begin
        div_d = div_q + 8'd1;
        if (period_end) begin
          state_d = SHIFT;
          div_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b0;
          mosi_d  = tx_q[7];
        end
      end

      SHIFT: begin
        div_d = div_q + 8'd1;
        if (period_end) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[6:0], sync2_q};
          end else if (bit_q == 3'd7) begin
            // High half after the 8th rising edge has elapsed: byte complete.
            state_d = HOLD;
            bit_d   = '0;
            odv_d   = 1'b1;
            out_d   = rx_q;
          end else begin
            sclk_d = 1'b0;
            bit_d  = bit_q + 3'd1;
            tx_d   = {tx_q[6:0], 1'b1};
            mosi_d = tx_q[6];
          end
        end
      end

      HOLD: begin
        div_d = div_q + 8'd1;
        if (accept) begin
          tx_d    = in_data;
          taken_d = 1'b1;
        end
        if (period_end) begin
          div_d   = '0;
          taken_d = 1'b0;
          if (taken_q || accept) begin
            state_d = SHIFT;
            sclk_d  = 1'b0;
            mosi_d  = accept ? in_data[7] : tx_q[7];
          end else begin
            state_d = GAP;
            cs_n_d  = 1'b1;
            mosi_d  = 1'b1;
          end
        end
      end

      GAP: begin
        div_d = div_q + 8'd1;
        if (period_end) begin
          div_d   = '0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      out_q   <= '0;
      sclk_q  <= 1'b1;
      mosi_q  <= 1'b1;
      cs_n_q  <= 1'b1;
      odv_q   <= 1'b0;
      taken_q <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      out_q   <= out_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      odv_q   <= odv_d;
      taken_q <= taken_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign SPI_clock           = sclk_q;
  assign SPI_out             = mosi_q;
  assign SPI_not_chip_select = cs_n_q;
  assign out_data_valid      = odv_q;
  assign out_data            = out_q;
  assign active              = (state_q != IDLE);

endmodule

// File: tb/tb_spi_tx.sv
// Bench for spi_tx: per-cycle comparison against a timeline model of a session,
// directed scenarios with literal expectations, randomized sessions, and a DIV=4 instance.
module tb_spi_tx;

  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst_n, v, rdy, sclk, mosi, miso, ncs, odv, act;
  logic [7:0] d, od;
  int         mode;

  logic       rst4_n, v4, rdy4, sclk4, mosi4, ncs4, odv4, act4;
  logic [7:0] d4, od4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign miso = (mode == 0) ? mosi : (mode == 1) ? ~mosi : (mode == 3);

  spi_tx #(.CLOCK_DIVIDER(D)) dut (
    .clock(clk), .reset(rst_n), .SPI_clock(sclk), .SPI_out(mosi), .SPI_in(miso),
    .SPI_not_chip_select(ncs), .in_data_valid(v), .in_data(d), .in_data_ready(rdy),
    .out_data_valid(odv), .out_data(od), .active(act)
  );

  spi_tx #(.CLOCK_DIVIDER(4)) dut4 (
    .clock(clk), .reset(rst4_n), .SPI_clock(sclk4), .SPI_out(mosi4), .SPI_in(mosi4),
    .SPI_not_chip_select(ncs4), .in_data_valid(v4), .in_data(d4), .in_data_ready(rdy4),
    .out_data_valid(odv4), .out_data(od4), .active(act4)
  );

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      if (errors < 40) $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [7:0] exp_rx(input logic [7:0] b, input int md);
    case (md)
      0:       return b;
      1:       return ~b;
      2:       return 8'h00;
      default: return 8'hFF;
    endcase
  endfunction

  // Session timeline model: t counts cycles since chip select fell.
  bit         m_sess, m_gap, m_taken;
  int         m_t, m_bs, m_gs;
  logic [7:0] m_byte, m_next;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sess = 0; m_gap = 0; m_taken = 0; m_t = 0; m_bs = 0; m_gs = 0;
    end else if (!m_sess) begin
      if (v) begin
        m_sess = 1; m_gap = 0; m_taken = 0; m_t = 0; m_bs = D; m_byte = d;
      end
    end else begin
      if (!m_gap && m_t >= m_bs + 16 * D && !m_taken && v) begin
        m_taken = 1; m_next = d;
      end
      m_t++;
      if (m_gap) begin
        if (m_t == m_gs + D) m_sess = 0;
      end else if (m_t == m_bs + 17 * D) begin
        if (m_taken) begin
          m_bs = m_t; m_byte = m_next; m_taken = 0;
        end else begin
          m_gap = 1; m_gs = m_t;
        end
      end
    end
  end

  logic       e_cs, e_sclk, e_mosi, e_act, e_rdy, e_odv;
  logic [7:0] e_out, m_last;
  int         cu, ch;

  always @(negedge clk) begin
    if (!rst_n) m_last = 8'h00;
    e_cs = 1; e_sclk = 1; e_mosi = 1; e_act = 0; e_rdy = 1; e_odv = 0; e_out = m_last;
    if (m_sess) begin
      e_act = 1; e_rdy = 0;
      if (!m_gap) begin
        e_cs = 0;
        if (m_t >= D) begin
          cu = m_t - m_bs;
          ch = cu / D;
          if (ch < 16) begin
            e_sclk = (ch % 2) == 1;
            e_mosi = m_byte[7 - ch / 2];
          end else begin
            e_mosi = m_byte[0];
            e_rdy  = !m_taken;
            if (cu == 16 * D) begin
              e_odv = 1;
              e_out = exp_rx(m_byte, mode);
            end
          end
        end
      end
    end
    chk("ncs", 32'(ncs), 32'(e_cs));
    chk("sclk", 32'(sclk), 32'(e_sclk));
    chk("mosi", 32'(mosi), 32'(e_mosi));
    chk("active", 32'(act), 32'(e_act));
    chk("ready", 32'(rdy), 32'(e_rdy));
    chk("odv", 32'(odv), 32'(e_odv));
    chk("out_data", 32'(od), 32'(e_out));
    m_last = e_out;
  end

  // Observation for the directed literal checks.
  logic       p_sclk = 1'b1, p_cs = 1'b1;
  int         low_cnt = 0, last_low = 0, sclk_rises = 0;
  logic       mosi_bits[$];
  logic [7:0] rx_seen[$];

  always @(negedge clk) begin
    if (sclk && !p_sclk) begin
      sclk_rises++;
      mosi_bits.push_back(mosi);
    end
    if (!ncs) low_cnt++;
    else if (!p_cs) begin
      last_low = low_cnt;
      low_cnt  = 0;
    end
    if (odv) rx_seen.push_back(od);
    p_sclk = sclk;
    p_cs   = ncs;
  end

  task automatic offer(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    v = 1'b1; d = b;
    while (!rdy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("offer_timeout", 32'(rdy), 1);
    if (rdy) begin
      @(posedge clk);
      #1;
    end
    v = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (act && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(act), 0);
  endtask

  // DIV=4 instance: edge timing and loopback data.
  int         cyc4 = 0, p4_fall = -1, falls4 = 0, low4 = 0, last_low4 = 0;
  logic       p4_sclk = 1'b1, p4_cs = 1'b1;
  logic [7:0] rx4[$];
  bit         done4 = 0;

  always @(negedge clk) begin
    cyc4++;
    if (sclk4 != p4_sclk) begin
      chk("d4_edge_with_cs_high", 32'(ncs4), 0);
      if (sclk4) chk("d4_low_half", cyc4 - p4_fall, 4);
      else begin
        if (falls4 % 8 != 0) chk("d4_sclk_period", cyc4 - p4_fall, 8);
        falls4++;
        p4_fall = cyc4;
      end
    end
    if (!ncs4) low4++;
    else begin
      if (!p4_cs) last_low4 = low4;
      low4   = 0;
      falls4 = 0;
    end
    if (odv4) rx4.push_back(od4);
    p4_sclk = sclk4;
    p4_cs   = ncs4;
  end

  task automatic offer4(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    v4 = 1'b1; d4 = b;
    while (!rdy4 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("d4_offer_timeout", 32'(rdy4), 1);
    if (rdy4) begin
      @(posedge clk);
      #1;
    end
    v4 = 1'b0;
  endtask

  task automatic wait_idle4();
    int n = 0;
    @(negedge clk);
    while (act4 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("d4_idle_timeout", 32'(act4), 0);
  endtask

  initial begin
    logic [7:0] b0, b1, b2;
    rst4_n = 1'b0; v4 = 1'b0; d4 = 8'h00;
    repeat (3) @(negedge clk);
    rst4_n = 1'b1;
    b0 = 8'(($urandom));
    offer4(b0);
    wait_idle4();
    chk("d4_cs_low_single", last_low4, 72);
    chk("d4_rx_count1", rx4.size(), 1);
    if (rx4.size() >= 1) chk("d4_rx0", 32'(rx4[0]), 32'(b0));
    b1 = 8'(($urandom));
    b2 = 8'(($urandom));
    offer4(b1);
    offer4(b2);
    wait_idle4();
    chk("d4_cs_low_pair", last_low4, 140);
    chk("d4_rx_count3", rx4.size(), 3);
    if (rx4.size() >= 3) begin
      chk("d4_rx1", 32'(rx4[1]), 32'(b1));
      chk("d4_rx2", 32'(rx4[2]), 32'(b2));
    end
    done4 = 1;
  end

  initial begin
    int         i0, r0, n, k, nb;
    logic [7:0] a5, bq[$];
    rst_n = 1'b0; mode = 0; v = 1'b0; d = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ncs", 32'(ncs), 1);
    chk("rst_sclk", 32'(sclk), 1);
    chk("rst_mosi", 32'(mosi), 1);
    chk("rst_odv", 32'(odv), 0);
    chk("rst_out", 32'(od), 0);
    chk("rst_active", 32'(act), 0);
    rst_n = 1'b1;

    // Isolated 0xA5 looped back.
    a5 = 8'hA5;
    i0 = mosi_bits.size(); r0 = rx_seen.size();
    offer(a5);
    wait_idle();
    chk("a5_bit_count", mosi_bits.size() - i0, 8);
    for (int i = 0; i < 8; i++)
      if (i0 + i < mosi_bits.size()) chk("a5_mosi_bit", 32'(mosi_bits[i0 + i]), 32'(a5[7 - i]));
    chk("a5_rx_count", rx_seen.size() - r0, 1);
    if (rx_seen.size() > r0) chk("a5_rx", 32'(rx_seen[r0]), 32'hA5);
    chk("a5_cs_low", last_low, 144);

    // Back-to-back 0x3C, 0xC3.
    r0 = rx_seen.size();
    offer(8'h3C);
    offer(8'hC3);
    wait_idle();
    chk("b2b_rx_count", rx_seen.size() - r0, 2);
    if (rx_seen.size() > r0 + 1) begin
      chk("b2b_rx0", 32'(rx_seen[r0]), 32'h3C);
      chk("b2b_rx1", 32'(rx_seen[r0 + 1]), 32'hC3);
    end
    chk("b2b_cs_low", last_low, 280);

    // MISO tied high / low.
    mode = 3; r0 = rx_seen.size();
    offer(8'h00); wait_idle();
    if (rx_seen.size() > r0) chk("tied1_rx", 32'(rx_seen[r0]), 32'hFF);
    else chk("tied1_rx_count", rx_seen.size() - r0, 1);
    mode = 2; r0 = rx_seen.size();
    offer(8'hFF); wait_idle();
    if (rx_seen.size() > r0) chk("tied0_rx", 32'(rx_seen[r0]), 32'h00);
    else chk("tied0_rx_count", rx_seen.size() - r0, 1);

    // Abort after the 3rd SCLK rising edge.
    mode = 0; k = sclk_rises;
    offer(8'h5A);
    n = 0;
    while (sclk_rises < k + 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_rise_timeout", 32'(sclk_rises >= k + 3), 1);
    r0 = rx_seen.size();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_ncs", 32'(ncs), 1);
    chk("abort_sclk", 32'(sclk), 1);
    chk("abort_mosi", 32'(mosi), 1);
    chk("abort_odv", 32'(odv), 0);
    chk("abort_active", 32'(act), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("abort_no_rx", rx_seen.size() - r0, 0);
    offer(8'h81); wait_idle();
    chk("after_abort_count", rx_seen.size() - r0, 1);
    if (rx_seen.size() > r0) chk("after_abort_rx", 32'(rx_seen[r0]), 32'h81);

    // Valid held through SETUP/SHIFT: one byte per HOLD window.
    r0 = rx_seen.size();
    offer(8'h11); offer(8'h22); offer(8'h33);
    wait_idle();
    chk("held_rx_count", rx_seen.size() - r0, 3);
    chk("held_cs_low", last_low, (1 + 17 * 3) * D);

    // Randomized sessions.
    for (int s = 0; s < 20; s++) begin
      mode = int'($urandom_range(0, 3));
      nb   = int'($urandom_range(1, 3));
      bq.delete();
      r0 = rx_seen.size();
      repeat ($urandom_range(0, 5)) @(negedge clk);
      for (int j = 0; j < nb; j++) begin
        bq.push_back(8'($urandom));
        offer(bq[j]);
      end
      wait_idle();
      chk("rand_rx_count", rx_seen.size() - r0, nb);
      for (int j = 0; j < nb; j++)
        if (r0 + j < rx_seen.size()) chk("rand_rx", 32'(rx_seen[r0 + j]), 32'(exp_rx(bq[j], mode)));
      chk("rand_cs_low", last_low, (1 + 17 * nb) * D);
    end

    n = 0;
    while (!done4 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("d4_done_timeout", 32'(done4), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_tx.md
SPI_TX -- requirements
Module: spi_tx

Interface
REQ-001 SHALL have parameter CLOCK_DIVIDER, default 8: clock cycles per SPI_clock half-period, legal range 4..255.
REQ-002 SHALL have port clock, input, 1: single system clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1: reset is asynchronous and active-low.
REQ-004 SHALL have port SPI_clock, output, 1: SCLK, mode 3 (CPOL=1, CPHA=1), idles high.
REQ-005 SHALL have port SPI_out, output, 1: MOSI, MSB first.
REQ-006 SHALL have port SPI_in, input, 1: MISO, asynchronous to clock.
REQ-007 SHALL have port SPI_not_chip_select, output, 1: active-low chip select.
REQ-008 SHALL have port in_data_valid, input, 1: byte to transmit is offered.
REQ-009 SHALL have port in_data, input, 8: byte to transmit.
REQ-010 SHALL have port in_data_ready, output, 1: byte accepted when in_data_valid & in_data_ready are both high at a clock edge.
REQ-011 SHALL have port out_data_valid, output, 1: one-cycle pulse carrying a received byte; there is no backpressure.
REQ-012 SHALL have port out_data, output, 8: received byte, held stable until the next pulse.
REQ-013 SHALL have port active, output, 1: high whenever state != IDLE.

Function
REQ-014 SHALL run an FSM with states IDLE, SETUP, SHIFT, HOLD and GAP; a half-period counter counts 0..CLOCK_DIVIDER-1 and a 3-bit bit counter tracks the bit position.
REQ-015 SHALL, in IDLE, drive SPI_not_chip_select=1, SPI_clock=1 and in_data_ready=1.
REQ-016 SHALL, on an IDLE handshake, load in_data into the tx shift register, drive chip select low on the next cycle, and enter SETUP.
REQ-017 SHALL remain in SETUP for CLOCK_DIVIDER cycles with SPI_clock high, then enter SHIFT.
REQ-018 SHALL, on entering SHIFT, drive SPI_clock low and SPI_out=bit7 in the same cycle; each later SCLK falling edge SHALL present the next lower bit.
REQ-019 SHALL toggle SPI_clock every CLOCK_DIVIDER cycles in SHIFT, giving 8 falling and 8 rising edges per byte.
REQ-020 SHALL pass SPI_in through a 2-flop synchronizer and shift the synchronized value into the rx register, MSB first, in the cycle SPI_clock goes high.
REQ-021 SHALL, after the 8th rising edge, enter HOLD and pulse out_data_valid for exactly one cycle with out_data equal to the 8 sampled bits.
REQ-022 SHALL hold in_data_ready=0 in SETUP, SHIFT and GAP; valid bytes offered in those states are not consumed.
REQ-023 SHALL assert in_data_ready in HOLD and accept at most one byte there; an accepted byte is loaded into the tx shift register and ready drops the next cycle.
REQ-024 SHALL stay in HOLD for CLOCK_DIVIDER cycles with SPI_clock high; at its end, if a byte was accepted, it enters SHIFT (chip select stays low, back-to-back bytes).
REQ-025 SHALL, at the end of HOLD with no byte accepted, drive chip select high and enter GAP for CLOCK_DIVIDER cycles, then return to IDLE.
REQ-026 SHALL keep chip select low for exactly 18*CLOCK_DIVIDER cycles for an isolated byte, and for (1+17*N)*CLOCK_DIVIDER cycles for N back-to-back bytes.
REQ-027 SHALL drive SPI_out=1 in IDLE, GAP and SETUP.
REQ-028 SHALL wrap the 3-bit bit counter from 7 to 0 at each byte boundary and never let it exceed 8 edges per byte.

Reset
REQ-029 SHALL, while reset=0, force the following immediately, without waiting for a clock: state=IDLE, SPI_clock=1, SPI_not_chip_select=1, SPI_out=1, out_data_valid=0, out_data=0x00, active=0, all counters, shift registers and synchronizer flops cleared, and handshakes ignored.
REQ-030 SHALL abort any byte in progress on a mid-operation reset, discarding partial rx/tx bits; no out_data_valid is produced for an aborted byte.

Verification
REQ-031 SHALL cover: DIV=8, SPI_in looped to SPI_out, send 0xA5 -> MOSI bits 1,0,1,0,0,1,0,1; one out_data_valid with out_data=0xA5; chip select low 144 cycles.
REQ-032 SHALL cover: 0x3C and 0xC3 both offered while in HOLD-ready windows -> chip select never rises between bytes; out_data=0x3C then 0xC3; low for 280 cycles.
REQ-033 SHALL cover: SPI_in tied 1, send 0x00 -> out_data=0xFF; SPI_in tied 0, send 0xFF -> out_data=0x00.
REQ-034 SHALL cover: reset=0 asserted after the 3rd SCLK rising edge -> chip select, SPI_clock and SPI_out=1 with no clock edge; no out_data_valid; after release, 0x81 transfers correctly.
REQ-035 SHALL cover: in_data_valid held during SHIFT -> no acceptance until HOLD; exactly one byte consumed per HOLD window.
REQ-036 SHALL cover: DIV=4 -> SCLK period 8 cycles; no SCLK edge occurs while chip select is high.
